// File: rtl/instr_fetch.sv
// MIPS instruction-fetch stage: PC register, req/ready fetch from instruction memory,
// instruction hold for decode, and next-PC selection from the J/B/Zero feedback.
module instr_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  input  logic               id_ready,
  input  logic               J,
  input  logic               B,
  input  logic               Zero,
  output logic               instr_valid,
  output logic [31:0]        PC,
  output logic [31:0]        Instr,
  output logic [5:0]         OpCode,
  output logic [5:0]         Funct,
  output logic [31:0]        retire_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retire_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] pc4;
  logic [31:0] jump_tgt;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  always_comb begin
    pc4      = pc_q + 32'd4;
    jump_tgt = {pc4[31:28], instr_q[25:0], 2'b00};
    br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    next_pc  = pc4;
    if (J) begin
      next_pc = jump_tgt;
    end else if (B && Zero) begin
      next_pc = pc4 + br_off;
    end
  end

  // Outputs are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= PC_RESET;
      instr_q  <= '0;
      retire_q <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StReq;
          req_q   <= 1'b1;
        end
        StReq: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= StHold;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (id_ready) begin
            pc_q     <= next_pc;
            retire_q <= retire_q + 32'd1;
            state_q  <= StReq;
            req_q    <= 1'b1;
            valid_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign instr_valid = valid_q;
  assign PC          = pc_q;
  assign Instr       = instr_q;
  assign OpCode      = instr_q[31:26];
  assign Funct       = instr_q[5:0];
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, sequential fetch, waits/stalls, jump, branch, reset abort.
module tb_instr_fetch;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          req_a, ready_a, id_ready_a, j_a, b_a, z_a, valid_a;
  logic [AW-1:0] addr_a;
  logic [31:0]   rdata_a, pc_a, instr_a, retire_a;
  logic [5:0]    op_a, fn_a;

  logic          req_j, id_ready_j, valid_j;
  logic [AW-1:0] addr_j;
  logic [31:0]   pc_j, instr_j, retire_j;
  logic [5:0]    op_j, fn_j;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch #(.PC_RESET(32'h0000_3000), .IMEM_AW(AW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (req_a),
    .imem_addr  (addr_a),
    .imem_ready (ready_a),
    .imem_rdata (rdata_a),
    .id_ready   (id_ready_a),
    .J          (j_a),
    .B          (b_a),
    .Zero       (z_a),
    .instr_valid(valid_a),
    .PC         (pc_a),
    .Instr      (instr_a),
    .OpCode     (op_a),
    .Funct      (fn_a),
    .retire_cnt (retire_a)
  );

  // Second instance placed high in the address space to exercise the jump's PC[31:28] keep.
  instr_fetch #(.PC_RESET(32'h1000_0010), .IMEM_AW(AW)) u_dut_j (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (req_j),
    .imem_addr  (addr_j),
    .imem_ready (1'b1),
    .imem_rdata (32'h0800_0040),
    .id_ready   (id_ready_j),
    .J          (1'b1),
    .B          (1'b0),
    .Zero       (1'b0),
    .instr_valid(valid_j),
    .PC         (pc_j),
    .Instr      (instr_j),
    .OpCode     (op_j),
    .Funct      (fn_j),
    .retire_cnt (retire_j)
  );

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    case (a)
      10'd0:   mem_word = 32'h0109_5020;
      10'd1:   mem_word = 32'h0109_5022;
      10'd2:   mem_word = 32'h0109_5024;
      10'd3:   mem_word = 32'h0109_5025;
      10'd4:   mem_word = 32'h0800_0008;  // j 0x20
      10'd5:   mem_word = 32'h0800_0008;  // j 0x20
      10'd8:   mem_word = 32'h1000_FFFC;  // beq, imm -4
      10'd9:   mem_word = 32'h0800_0010;  // j 0x40 (imm as branch would give 0x68)
      default: mem_word = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign rdata_a = mem_word(addr_a);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    ready_a    = 1'b1;
    id_ready_a = 1'b1;
    j_a        = 1'b0;
    b_a        = 1'b0;
    z_a        = 1'b0;
    id_ready_j = 1'b0;

    step();
    step();
    check("rst_pc", pc_a, 32'h0000_3000);
    check("rst_req", {31'd0, req_a}, 32'd0);
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_retire", retire_a, 32'd0);
    check("rst_instr", instr_a, 32'd0);
    check("rst_addr", {22'd0, addr_a}, 32'd0);

    rst_n = 1'b1;
    step();
    check("first_req", {31'd0, req_a}, 32'd1);
    check("first_addr", {22'd0, addr_a}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      check("seq_req", {31'd0, req_a}, 32'd1);
      check("seq_req_valid", {31'd0, valid_a}, 32'd0);
      check("seq_addr", {22'd0, addr_a}, i);
      step();
      check("seq_valid", {31'd0, valid_a}, 32'd1);
      check("seq_pc", pc_a, 32'h0000_3000 + 32'(4 * i));
      check("seq_instr", instr_a, mem_word(AW'(i)));
    end
    check("seq_opcode", {26'd0, op_a}, 32'h00);
    check("seq_funct", {26'd0, fn_a}, 32'h25);
    step();
    check("seq_retire", retire_a, 32'd4);

    ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_addr", {22'd0, addr_a}, 32'd4);
      check("wait_valid", {31'd0, valid_a}, 32'd0);
      check("wait_req", {31'd0, req_a}, 32'd1);
    end
    ready_a = 1'b1;
    step();
    check("wait_done_valid", {31'd0, valid_a}, 32'd1);
    check("wait_done_instr", instr_a, 32'h0800_0008);

    id_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'd0, valid_a}, 32'd1);
      check("stall_pc", pc_a, 32'h0000_3010);
      check("stall_instr", instr_a, 32'h0800_0008);
      check("stall_retire", retire_a, 32'd4);
    end

    id_ready_a = 1'b1;
    j_a = 1'b1;
    step();
    j_a = 1'b0;
    check("jmp_pc", pc_a, 32'h0000_0020);
    check("jmp_addr", {22'd0, addr_a}, 32'd8);
    check("jmp_retire", retire_a, 32'd5);
    step();
    check("beq_opcode", {26'd0, op_a}, 32'h04);
    check("beq_funct", {26'd0, fn_a}, 32'h3C);
    b_a = 1'b1;
    z_a = 1'b1;
    step();
    b_a = 1'b0;
    z_a = 1'b0;
    check("br_taken_pc", pc_a, 32'h0000_0014);
    step();
    j_a = 1'b1;
    step();
    j_a = 1'b0;
    check("jmp_back_pc", pc_a, 32'h0000_0020);
    step();
    b_a = 1'b1;
    step();
    b_a = 1'b0;
    check("br_not_taken_pc", pc_a, 32'h0000_0024);
    step();
    j_a = 1'b1;
    b_a = 1'b1;
    z_a = 1'b1;
    step();
    j_a = 1'b0;
    b_a = 1'b0;
    z_a = 1'b0;
    check("jb_prio_pc", pc_a, 32'h0000_0040);
    check("jb_retire", retire_a, 32'd9);

    ready_a = 1'b0;
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ready_a = ~ready_a;
      step();
      check("abort_pc", pc_a, 32'h0000_3000);
      check("abort_valid", {31'd0, valid_a}, 32'd0);
      check("abort_instr", instr_a, 32'd0);
      check("abort_retire", retire_a, 32'd0);
    end
    ready_a = 1'b1;
    rst_n = 1'b1;
    step();
    check("stale_valid", {31'd0, valid_a}, 32'd0);
    check("stale_instr", instr_a, 32'd0);
    check("stale_req", {31'd0, req_a}, 32'd1);

    step();
    check("hj_valid", {31'd0, valid_j}, 32'd1);
    check("hj_pc", pc_j, 32'h1000_0010);
    check("hj_instr", instr_j, 32'h0800_0040);
    check("hj_opcode", {26'd0, op_j}, 32'h02);
    check("hj_funct", {26'd0, fn_j}, 32'h00);
    check("hj_req", {31'd0, req_j}, 32'd0);
    id_ready_j = 1'b1;
    step();
    id_ready_j = 1'b0;
    check("hj_next_pc", pc_j, 32'h1000_0100);
    check("hj_addr", {22'd0, addr_j}, 32'h040);
    check("hj_retire", retire_j, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
